// File: rtl/axi_write_slave.sv
// AXI-style write-channel slave: accepts one burst at a time into a word-addressed
// memory with byte strobes, returns one response per burst, exposes a debug read port.
module axi_write_slave #(
  parameter int DEPTH  = 256,
  parameter int AW_IDX = $clog2(DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [3:0]        AWID,
  input  logic [31:0]       AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [2:0]        AWSIZE,
  input  logic [1:0]        AWBURST,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [3:0]        WID,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [3:0]        BID,
  output logic [3:0]        BRESP,
  input  logic [AW_IDX-1:0] dbg_addr,
  output logic [31:0]       dbg_rdata
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  localparam logic [1:0] BURST_SINGLE = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] BURST_WRAP4  = 2'b10;

  state_t      state, state_next;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [4:0]  beats_q;
  logic        err_q;

  logic        aw_fire, w_fire, b_fire;
  logic        last_beat, addr_oor, beat_err;
  logic [31:0] step, wrap_mask, addr_next;
  logic [4:0]  beat_count;
  logic [31:0] mem [DEPTH];

  // WID has no function here; it is folded away so it does not look forgotten.
  logic unused_wid;
  assign unused_wid = ^WID;

  always_comb begin
    aw_fire   = AWVALID && AWREADY;
    w_fire    = WVALID && WREADY;
    b_fire    = BVALID && BREADY;
    last_beat = (beats_q == 5'd1);
    addr_oor  = ((addr_q >> (AW_IDX + 2)) != 32'd0);
    beat_err  = addr_oor || (WLAST != last_beat);
    step      = 32'd1 << size_q;
    wrap_mask = (step << 2) - 32'd1;

    case (burst_q)
      BURST_SINGLE: addr_next = addr_q;
      BURST_WRAP4:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:      addr_next = addr_q + step;
    endcase

    case (AWBURST)
      BURST_SINGLE: beat_count = 5'd1;
      BURST_INCR:   beat_count = {1'b0, AWLEN} + 5'd1;
      default:      beat_count = 5'd4;
    endcase

    state_next = state;
    case (state)
      IDLE: if (aw_fire) state_next = DATA;
      DATA: if (w_fire && last_beat) state_next = RESP;
      RESP: if (b_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= 4'd0;
      BRESP   <= 4'd0;
      id_q    <= 4'd0;
      addr_q  <= 32'd0;
      size_q  <= 3'd0;
      burst_q <= 2'd0;
      beats_q <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_next;
      AWREADY <= (state_next == IDLE);
      WREADY  <= (state_next == DATA);
      if (aw_fire) begin
        id_q    <= AWID;
        addr_q  <= AWADDR;
        size_q  <= AWSIZE;
        burst_q <= AWBURST;
        beats_q <= beat_count;
        err_q   <= (AWSIZE > 3'd2);
      end
      if (w_fire) begin
        addr_q  <= addr_next;
        beats_q <= beats_q - 5'd1;
        err_q   <= err_q || beat_err;
      end
      if (w_fire && last_beat) begin
        BVALID <= 1'b1;
        BID    <= id_q;
        BRESP  <= (err_q || beat_err) ? 4'd2 : 4'd0;
      end else if (b_fire) begin
        BVALID <= 1'b0;
      end
    end
  end

  // Memory is deliberately unreset; out-of-range beats are dropped here.
  always_ff @(posedge ACLK) begin
    if (w_fire && !addr_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (WSTRB[i]) mem[addr_q[AW_IDX+1:2]][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule
